// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision alignment path: field widths,
// the packed operand layout and helpers that expand an operand into its
// effective exponent and 25-bit mantissa.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MAN_W  = 25;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    // Denormals (exp 0) behave as exponent 1 with no hidden bit.
    function automatic logic [EXP_W-1:0] exp_eff(input fp32_t x);
        return (x.exp == '0) ? 8'd1 : x.exp;
    endfunction

    // {guard 0, hidden, fraction}
    function automatic logic [MAN_W-1:0] mant_of(input fp32_t x);
        return {1'b0, (x.exp != '0), x.frac};
    endfunction

endpackage

// File: rtl/fp_rshift_sticky.sv
// Combinational right shifter for the small mantissa. A saturate request
// clears the result and folds every input bit into sticky.
module fp_rshift_sticky
    import fp_pkg::*;
(
    input  logic [MAN_W-1:0] din,
    input  logic [4:0]       amt,
    input  logic             sat,
    output logic [MAN_W-1:0] dout,
    output logic             sticky
);

    logic [MAN_W-1:0] keep_mask;

    // Shift and collect the bits that fall off the bottom
    always_comb begin
        dout      = '0;
        sticky    = 1'b0;
        keep_mask = {MAN_W{1'b1}} << amt;
        if (sat) begin
            dout   = '0;
            sticky = |din;
        end else begin
            dout   = din >> amt;
            sticky = |(din & ~keep_mask);
        end
    end

endmodule

// File: rtl/fp_align.sv
// Two-stage operand alignment ahead of the 25-bit mantissa adder.
// S1 picks the larger magnitude and the exponent difference, S2 shifts the
// smaller mantissa. Build option FP_ALIGN_STICKY_EN drives the sticky output
// and jams it into bit 0 of man_small; without it sticky is 0 and the shift
// is plain truncation.
module fp_align
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           a,
    input  logic [31:0]           b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] man_big,
    output logic [DATA_WIDTH-1:0] man_small,
    output logic [7:0]            exp_out,
    output logic                  sign_big,
    output logic                  sign_small,
    output logic                  swapped,
    output logic                  sticky,
    output logic                  special
);

    fp32_t            op_a, op_b;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             b_big;
    logic             is_special;

    logic             s1_valid;
    logic [MAN_W-1:0] s1_man_big, s1_man_small;
    logic [EXP_W-1:0] s1_exp, s1_diff;
    logic             s1_sign_big, s1_sign_small, s1_swapped, s1_special;

    logic             s2_adv, s1_open;
    logic             sh_sat, sh_sticky;
    logic [MAN_W-1:0] sh_out;
    logic [MAN_W-1:0] small_next;
    logic             sticky_next;

    // Operand decode and magnitude compare; ties keep a as the big operand
    always_comb begin
        op_a       = a;
        op_b       = b;
        ea         = exp_eff(op_a);
        eb         = exp_eff(op_b);
        ma         = mant_of(op_a);
        mb         = mant_of(op_b);
        b_big      = {eb, mb[MAN_W-2:0]} > {ea, ma[MAN_W-2:0]};
        is_special = (op_a.exp == EXP_SPECIAL) || (op_b.exp == EXP_SPECIAL);
    end

    // Handshake: S2 frees up when empty or draining, S1 when it can move on
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_open  = !s1_valid || s2_adv;
        in_ready = !rst && s1_open;
        sh_sat   = s1_diff >= 8'd25;
    end

    fp_rshift_sticky u_shift (
        .din    (s1_man_small),
        .amt    (s1_diff[4:0]),
        .sat    (sh_sat),
        .dout   (sh_out),
        .sticky (sh_sticky)
    );

`ifdef FP_ALIGN_STICKY_EN
    // Jam sticky into the LSB of the shifted mantissa
    always_comb begin
        small_next  = sh_out | {{(MAN_W-1){1'b0}}, sh_sticky};
        sticky_next = sh_sticky;
    end
`else
    logic unused_sticky;

    // Plain truncating shift, sticky reported as 0
    always_comb begin
        small_next    = sh_out;
        sticky_next   = 1'b0;
        unused_sticky = sh_sticky;
    end
`endif

    // Pipeline registers for both stages
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_man_big    <= '0;
            s1_man_small  <= '0;
            s1_exp        <= '0;
            s1_diff       <= '0;
            s1_sign_big   <= 1'b0;
            s1_sign_small <= 1'b0;
            s1_swapped    <= 1'b0;
            s1_special    <= 1'b0;
            out_valid     <= 1'b0;
            man_big       <= '0;
            man_small     <= '0;
            exp_out       <= '0;
            sign_big      <= 1'b0;
            sign_small    <= 1'b0;
            swapped       <= 1'b0;
            sticky        <= 1'b0;
            special       <= 1'b0;
        end else begin
            if (s1_open) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_man_big    <= b_big ? mb : ma;
                    s1_man_small  <= b_big ? ma : mb;
                    s1_exp        <= b_big ? eb : ea;
                    s1_diff       <= b_big ? (eb - ea) : (ea - eb);
                    s1_sign_big   <= b_big ? op_b.sign : op_a.sign;
                    s1_sign_small <= b_big ? op_a.sign : op_b.sign;
                    s1_swapped    <= b_big;
                    s1_special    <= is_special;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    man_big    <= s1_man_big;
                    man_small  <= small_next;
                    exp_out    <= s1_exp;
                    sign_big   <= s1_sign_big;
                    sign_small <= s1_sign_small;
                    swapped    <= s1_swapped;
                    sticky     <= sticky_next;
                    special    <= s1_special;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_align.sv
// Directed bench for fp_align; expectations follow FP_ALIGN_STICKY_EN.
module tb_fp_align;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b;
    logic [24:0] man_big, man_small;
    logic [7:0]  exp_out;
    logic        sign_big, sign_small, swapped, sticky, special;

    int vectors     = 0;
    int miscompares = 0;

`ifdef FP_ALIGN_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [24:0] mb;
        logic [24:0] ms;
        logic [7:0]  e;
        logic        sb, ss, sw, st, sp;
    } vec_t;

    always #5 clk = ~clk;

    fp_align #(.DATA_WIDTH(25)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .man_big(man_big), .man_small(man_small), .exp_out(exp_out),
        .sign_big(sign_big), .sign_small(sign_small), .swapped(swapped),
        .sticky(sticky), .special(special)
    );

    function automatic vec_t mk(input logic [31:0] va, vb, input logic [24:0] emb, ems,
                                input logic [7:0] ee, input logic esb, ess, esw, est, esp);
        vec_t v;
        v = {va, vb, emb, ems, ee, esb, ess, esw, est, esp};
        return v;
    endfunction

    function automatic logic [62:0] outs();
        return {man_big, man_small, exp_out, sign_big, sign_small, swapped, sticky, special};
    endfunction

    // Drive one pair into an idle pipe and wait for its result (lat = -1 on timeout)
    task automatic send_pair(input logic [31:0] va, vb, output int lat);
        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        vectors++;
        if ({out_valid, outs()} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required 0", {out_valid, outs()});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_align();
        vec_t tv[$];
        int   lat;
        tv.push_back(mk(32'h3F800000, 32'h3F800000, 25'h0800000, 25'h0800000, 8'd127, 0, 0, 0, 0, 0));
        tv.push_back(mk(32'h3F800000, 32'h40400000, 25'h0C00000, 25'h0400000, 8'd128, 0, 0, 1, 0, 0));
        tv.push_back(mk(32'h3F800000, 32'hBF800000, 25'h0800000, 25'h0800000, 8'd127, 0, 1, 0, 0, 0));
        tv.push_back(mk(32'h3F800000, 32'h3F800001, 25'h0800001, 25'h0800000, 8'd127, 0, 0, 1, 0, 0));
        tv.push_back(mk(32'hC0000000, 32'h3F800000, 25'h0800000, 25'h0400000, 8'd128, 1, 0, 0, 0, 0));
        tv.push_back(mk(32'h00800000, 32'h00000002, 25'h0800000, 25'h0000002, 8'd1,   0, 0, 0, 0, 0));
        tv.push_back(mk(32'h00000003, 32'h00800000, 25'h0800000, 25'h0000003, 8'd1,   0, 0, 1, 0, 0));
        foreach (tv[i]) begin
            send_pair(tv[i].a, tv[i].b, lat);
            vectors++;
            if (lat !== 2) begin
                miscompares++;
                $display("FAIL align_latency[%0d]: got %0d required 2", i, lat);
            end
            vectors++;
            if (outs() !== tv[i][62:0]) begin
                miscompares++;
                $display("FAIL align[%0d]: got %h required %h", i, outs(), tv[i][62:0]);
            end
        end
    endtask

    task automatic test_sticky();
        vec_t tv[$];
        int   lat;
        // diff 24: everything shifted out, hidden bit lands in sticky
        tv.push_back(mk(32'h4B800000, 32'h3F800001, 25'h0800000, STICKY_ON ? 25'h1 : 25'h0,
                        8'd151, 0, 0, 0, STICKY_ON, 0));
        // diff 30: saturated
        tv.push_back(mk(32'h4E800000, 32'h3F800000, 25'h0800000, STICKY_ON ? 25'h1 : 25'h0,
                        8'd157, 0, 0, 0, STICKY_ON, 0));
        // diff 25: first saturated amount
        tv.push_back(mk(32'h4C000000, 32'h3F800000, 25'h0800000, STICKY_ON ? 25'h1 : 25'h0,
                        8'd152, 0, 0, 0, STICKY_ON, 0));
        // diff 1 losing a set LSB
        tv.push_back(mk(32'h40000000, 32'h3F800001, 25'h0800000,
                        STICKY_ON ? 25'h0400001 : 25'h0400000, 8'd128, 0, 0, 0, STICKY_ON, 0));
        // diff 23: hidden bit survives in bit 0, nothing lost
        tv.push_back(mk(32'h3F800000, 32'h4B000000, 25'h0800000, 25'h0000001,
                        8'd150, 0, 0, 1, 0, 0));
        foreach (tv[i]) begin
            send_pair(tv[i].a, tv[i].b, lat);
            vectors++;
            if (lat !== 2 || outs() !== tv[i][62:0]) begin
                miscompares++;
                $display("FAIL sticky[%0d]: got %h lat %0d required %h lat 2",
                         i, outs(), lat, tv[i][62:0]);
            end
        end
    endtask

    task automatic test_special();
        vec_t tv[$];
        int   lat;
        tv.push_back(mk(32'h7F800000, 32'h00000001, 25'h0800000, STICKY_ON ? 25'h1 : 25'h0,
                        8'd255, 0, 0, 0, STICKY_ON, 1));
        tv.push_back(mk(32'hFFC00000, 32'h3F800000, 25'h0C00000, STICKY_ON ? 25'h1 : 25'h0,
                        8'd255, 1, 0, 0, STICKY_ON, 1));
        tv.push_back(mk(32'h3F800000, 32'h7F800000, 25'h0800000, STICKY_ON ? 25'h1 : 25'h0,
                        8'd255, 0, 0, 1, STICKY_ON, 1));
        foreach (tv[i]) begin
            send_pair(tv[i].a, tv[i].b, lat);
            vectors++;
            if (lat !== 2 || outs() !== tv[i][62:0]) begin
                miscompares++;
                $display("FAIL special[%0d]: got %h lat %0d required %h lat 2",
                         i, outs(), lat, tv[i][62:0]);
            end
        end
    endtask

    function automatic logic [63:0] stream_pair(input int i);
        logic [31:0] big;
        big = {1'b0, 8'(127 + i), 23'h0};
        return (i % 2 == 1) ? {32'h3F800000, big} : {big, 32'h3F800000};
    endfunction

    task automatic test_back_to_back();
        int          sent = 0, rcvd = 0;
        logic        stalled = 1'b0;
        logic [62:0] held = '0, want;
        logic [63:0] p;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                p = stream_pair(sent);
                a = p[63:32];
                b = p[31:0];
            end
            #1;
            if (stalled && out_valid) begin
                vectors++;
                if (outs() !== held) begin
                    miscompares++;
                    $display("FAIL b2b_stall_stable c%0d: got %h required %h", c, outs(), held);
                end
            end
            if (c >= 3 && c <= 5) begin
                vectors++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_backpressure c%0d: got in_ready %b out_valid %b required 0 1",
                             c, in_ready, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (rcvd >= 8) begin
                    miscompares++;
                    $display("FAIL b2b_extra c%0d: got result %0d required none", c, rcvd);
                end else begin
                    want = {25'h0800000, 25'h0800000 >> rcvd, 8'(127 + rcvd),
                            1'b0, 1'b0, (rcvd % 2 == 1), 1'b0, 1'b0};
                    if (outs() !== want) begin
                        miscompares++;
                        $display("FAIL b2b_result[%0d]: got %h required %h", rcvd, outs(), want);
                    end
                end
                rcvd++;
            end
            stalled = out_valid && !out_ready;
            held    = outs();
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        vectors++;
        if (sent != 8 || rcvd != 8) begin
            miscompares++;
            $display("FAIL b2b_count: got sent %0d rcvd %0d required 8 8", sent, rcvd);
        end
    endtask

    task automatic test_reset_in_flight();
        int lat;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 32'h40400000; b = 32'h3F800000;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flight_rst_in_ready: got %b required 0", in_ready);
        end
        @(negedge clk);
        vectors++;
        if ({out_valid, outs()} !== 64'd0) begin
            miscompares++;
            $display("FAIL flight_rst_cleared: got %h required 0", {out_valid, outs()});
        end
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flight_stale c%0d: got out_valid %b required 0", c, out_valid);
            end
        end
        send_pair(32'h3F800000, 32'h40400000, lat);
        vectors++;
        if (lat !== 2 || outs() !== {25'h0C00000, 25'h0400000, 8'd128, 5'b00100}) begin
            miscompares++;
            $display("FAIL flight_recover: got %h lat %0d required %h lat 2",
                     outs(), lat, {25'h0C00000, 25'h0400000, 8'd128, 5'b00100});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_align();
        test_sticky();
        test_special();
        test_back_to_back();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
